// File: rtl/skid_fifo_reg.sv
// skid_fifo_reg: fully registered elastic buffer for valid/ready streams.
// Every output (m_valid, m_data, s_ready, count) is a flop, which cuts the
// valid and ready timing paths while sustaining one word per cycle.
//
// Parameters:
//   N      data width
//   DEPTH  total capacity, output register included (power of two, 2..64)
//   CW     occupancy width, derived, not overridable
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   s_valid/s_data   upstream stream, s_ready back to upstream
//   m_valid/m_data   downstream stream, m_ready from downstream
//   flush            synchronous discard of all contents
//   count            current occupancy 0..DEPTH
//   stall_cnt        saturating count of cycles with m_valid & ~m_ready
// Build option:
//   SKID_FIFO_STALL_CNT_EN  enables stall_cnt (tied to zero otherwise)

module skid_fifo_reg #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [N-1:0]  s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [N-1:0]  m_data,
    input  logic          m_ready,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [15:0]   stall_cnt
);

    // Array behind the head register holds DEPTH-1 entries.
    localparam int AD = DEPTH - 1;
    localparam int PW = (AD > 1) ? $clog2(AD) : 1;
    localparam logic [PW-1:0] PLAST = PW'(AD - 1);

    logic [N-1:0]  mem [AD];
    logic [N-1:0]  head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          arr_empty;
    logic          arr_load;
    logic          bypass;
    logic          arr_write;
    logic [CW-1:0] count_next;

    // Pointers wrap modulo DEPTH-1, which is not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + 1'b1;
    endfunction

    assign push       = s_valid & s_ready;
    assign pop        = m_valid & m_ready;
    // Head holds one word whenever count != 0, so the array is empty at <=1.
    assign arr_empty  = (count <= CW'(1));
    assign count_next = count + CW'(push) - CW'(pop);

    // Refill the head from the array when it drains; otherwise a push goes
    // straight into an empty (or emptying) head, or queues in the array.
    assign arr_load   = pop & ~arr_empty;
    assign bypass     = push & (~m_valid | pop) & arr_empty;
    assign arr_write  = push & ~bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_ready <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            count   <= count_next;
            m_valid <= (count_next != '0);
            s_ready <= (count_next < CW'(DEPTH));
            if (arr_load) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (arr_write) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
        end
    end

    // Data storage needs no reset; validity is tracked by count/m_valid.
    always_ff @(posedge clk) begin
        if (arr_write) begin
            mem[wr_ptr] <= s_data;
        end
        if (arr_load) begin
            head <= mem[rd_ptr];
        end else if (bypass) begin
            head <= s_data;
        end
    end

    assign m_data = head;

`ifdef SKID_FIFO_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_skid_fifo_reg.sv
// tb_skid_fifo_reg: self-checking bench for skid_fifo_reg.
// Accepted words go into a scoreboard queue and are compared on each pop.

module tb_skid_fifo_reg;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [N-1:0]  s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [N-1:0]  m_data;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;
    logic [15:0]   stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] sb [$];
    logic prev_rst = 1'b1;

    skid_fifo_reg #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .flush     (flush),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: state after the last edge is compared first, then this
    // cycle's transfers are applied to the queue.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (!prev_rst) begin
                check("count", 32'(count), 32'(sb.size()));
                check("m_valid", 32'(m_valid), 32'(sb.size() != 0));
                check("s_ready", 32'(s_ready), 32'(sb.size() < DEPTH));
            end
            if (m_valid && m_ready) begin
                check("pop_nonempty", 32'(sb.size() != 0), 32'(1));
                if (sb.size() != 0) begin
                    check("m_data", m_data, sb.pop_front());
                end
            end
            if (flush) begin
                sb.delete();
            end else if (s_valid && s_ready) begin
                sb.push_back(s_data);
            end
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; cyc returns cycles taken.
    task automatic send(input logic [N-1:0] d, input int budget,
                        output int cyc);
        logic acc;
        s_valid = 1'b1;
        s_data  = d;
        cyc     = 0;
        while (1) begin
            acc = s_ready;
            tick();
            cyc++;
            if (acc) break;
            if (cyc >= budget) begin
                check("send_timeout", 32'(cyc), 32'(budget - 1));
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int k;
        m_ready = 1'b1;
        k = 0;
        while ((m_valid || sb.size() != 0) && k < 50) begin
            tick();
            k++;
        end
        check(tag, 32'(m_valid), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int total;
        logic acc;

        // Reset / idle
        rst = 1'b1;
        repeat (3) begin
            tick();
            check("rst_m_valid", 32'(m_valid), 32'(0));
            check("rst_count", 32'(count), 32'(0));
            check("rst_s_ready", 32'(s_ready), 32'(0));
            check("rst_stall", 32'(stall_cnt), 32'(0));
        end
        rst = 1'b0;
        check("rel_s_ready_lo", 32'(s_ready), 32'(0));
        tick();
        check("rel_s_ready_hi", 32'(s_ready), 32'(1));
        check("rel_m_valid", 32'(m_valid), 32'(0));

        // Single word
        m_ready = 1'b1;
        send(32'hA5A5_A5A5, 5, c);
        s_valid = 1'b0;
        check("single_valid", 32'(m_valid), 32'(1));
        check("single_data", m_data, 32'hA5A5_A5A5);
        tick();
        check("single_count", 32'(count), 32'(0));
        check("single_empty", 32'(m_valid), 32'(0));

        // Fill / drain
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(N'(i), 5, c);
            check("fill_cycles", 32'(c), 32'(1));
        end
        s_data = 32'h5;
        check("full_s_ready", 32'(s_ready), 32'(0));
        check("full_count", 32'(count), 32'(4));
        tick();
        check("held_s_ready", 32'(s_ready), 32'(0));
        check("held_count", 32'(count), 32'(4));
        check("held_head", m_data, 32'h1);
        m_ready = 1'b1;
        tick();
        check("pop_s_ready", 32'(s_ready), 32'(1));
        check("pop_count", 32'(count), 32'(3));
        tick();
        s_valid = 1'b0;
        check("pushpop_count", 32'(count), 32'(3));
        drain("fill_drain");

        // Full throughput, continuous push with m_ready=1
        m_ready = 1'b1;
        total = 0;
        for (int i = 1; i <= 200; i++) begin
            send(N'(i), 5, c);
            total += c;
        end
        s_valid = 1'b0;
        check("thru_cycles", 32'(total), 32'(200));
        drain("thru_drain");

        // Random valid / ready
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!s_valid || acc) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
            end
            m_ready = 1'($urandom_range(0, 1));
            acc = s_valid & s_ready;
            tick();
        end
        s_valid = 1'b0;
        drain("rand_drain");

        // Flush with simultaneous push
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h100 + N'(i), 5, c);
        end
        s_valid = 1'b0;
        check("pre_flush_count", 32'(count), 32'(3));
        s_valid = 1'b1;
        s_data  = 32'h0000_DEAD;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flush_count", 32'(count), 32'(0));
        check("flush_m_valid", 32'(m_valid), 32'(0));
        check("flush_s_ready", 32'(s_ready), 32'(1));
        m_ready = 1'b1;
        repeat (4) begin
            tick();
            check("no_dead", 32'(m_valid), 32'(0));
        end

        // Stall counter
        m_ready = 1'b0;
        send(32'h77, 5, c);
        s_valid = 1'b0;
        check("stall_valid", 32'(m_valid), 32'(1));
        check("stall_start", 32'(stall_cnt), 32'(0));
        repeat (10) tick();
`ifdef SKID_FIFO_STALL_CNT_EN
        check("stall_10", 32'(stall_cnt), 32'(10));
        repeat (70000) tick();
        check("stall_sat", 32'(stall_cnt), 32'hFFFF);
`else
        check("stall_off", 32'(stall_cnt), 32'(0));
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_flush", 32'(stall_cnt), 32'(0));
        check("stall_flush_cnt", 32'(count), 32'(0));

        // Reset mid-stream
        m_ready = 1'b0;
        send(32'h11, 5, c);
        send(32'h22, 5, c);
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_valid", 32'(m_valid), 32'(0));
        check("mid_rst_ready", 32'(s_ready), 32'(0));
        tick();
        check("mid_rel_ready", 32'(s_ready), 32'(1));
        m_ready = 1'b1;
        send(32'h33, 5, c);
        s_valid = 1'b0;
        check("after_rst_data", m_data, 32'h33);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
